// File: rtl/wt_dcache_port_arb.sv
// Read-port arbiter and flush sequencer for the write-through dcache array.
// Define WT_DCACHE_ARB_STARVE_EN to compile in the low-priority starvation guard.
module wt_dcache_port_arb #(
  parameter int NumPorts    = 3,
  parameter int MaxOutst    = 4,
  parameter int StarveLimit = 15,
  parameter int IdxW        = (NumPorts <= 2) ? 1 : $clog2(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] rd_req_i,
  input  logic [NumPorts-1:0] rd_prio_i,
  output logic [NumPorts-1:0] rd_ack_o,
  output logic                gnt_vld_o,
  output logic [IdxW-1:0]     gnt_idx_o,
  input  logic                mem_ready_i,
  input  logic                rsp_vld_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                wbuffer_empty_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  output logic                starve_o
);

  localparam int OutW = $clog2(MaxOutst + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WBUF  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t              state;
  logic [IdxW-1:0]     rr_ptr;
  logic [OutW-1:0]     outstanding;
  logic [OutW-1:0]     out_next;
  logic                flush_armed;
  logic                flush_start;
  logic                rsp_eff;
  logic                grant_en;
  logic                gnt_vld;
  logic [IdxW-1:0]     gnt_idx;
  logic [NumPorts-1:0] promoted;
  logic [NumPorts-1:0] hi_req;
  logic [NumPorts-1:0] lo_req;
  logic [NumPorts-1:0] cand;

  // flush_armed stops a flush_i held across ACK from immediately re-triggering
  assign flush_start = (state == IDLE) & flush_i & flush_armed;
  assign rsp_eff     = rsp_vld_i & (outstanding != {OutW{1'b0}});
  assign grant_en    = ~rst_i & (state == IDLE) & ~flush_start & ~stall_i & mem_ready_i &
                       ((outstanding < OutW'(MaxOutst)) | rsp_vld_i);
  assign out_next    = outstanding + OutW'(gnt_vld) - OutW'(rsp_eff);

`ifdef WT_DCACHE_ARB_STARVE_EN
  localparam int CntW = $clog2(StarveLimit + 1);
  logic [CntW-1:0] starve_cnt [NumPorts];

  // per-port wait counters for low-class requesters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) starve_cnt[p] <= {CntW{1'b0}};
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (!rd_req_i[p] || rd_ack_o[p]) begin
          starve_cnt[p] <= {CntW{1'b0}};
        end else if (!rd_prio_i[p] && (starve_cnt[p] != CntW'(StarveLimit))) begin
          starve_cnt[p] <= starve_cnt[p] + CntW'(1);
        end else begin
          starve_cnt[p] <= starve_cnt[p];
        end
      end
    end
  end

  // saturated low-class requesters compete in the high class
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      promoted[p] = rd_req_i[p] & ~rd_prio_i[p] & (starve_cnt[p] == CntW'(StarveLimit));
    end
  end
`else
  assign promoted = {NumPorts{1'b0}};
`endif

  assign hi_req = rd_req_i & (rd_prio_i | promoted);
  assign lo_req = rd_req_i & ~rd_prio_i;
  assign cand   = (hi_req != {NumPorts{1'b0}}) ? hi_req : lo_req;

  // round-robin pick inside the eligible class, starting at rr_ptr
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = {IdxW{1'b0}};
    if (grant_en) begin
      for (int i = 0; i < NumPorts; i++) begin
        if (!gnt_vld && cand[IdxW'((int'(rr_ptr) + i) % NumPorts)]) begin
          gnt_vld = 1'b1;
          gnt_idx = IdxW'((int'(rr_ptr) + i) % NumPorts);
        end else begin
          gnt_vld = gnt_vld;
        end
      end
    end else begin
      gnt_vld = 1'b0;
    end
  end

  // one-hot ack decode
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rd_ack_o[p] = gnt_vld & (gnt_idx == IdxW'(p));
    end
  end

  assign gnt_vld_o   = gnt_vld;
  assign gnt_idx_o   = gnt_idx;
  assign starve_o    = gnt_vld & promoted[gnt_idx];
  assign flush_ack_o = (state == ACK);
  assign busy_o      = (outstanding != {OutW{1'b0}}) | (state != IDLE);

  // pointer, outstanding counter and flush FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= {IdxW{1'b0}};
      outstanding <= {OutW{1'b0}};
      flush_armed <= 1'b1;
    end else begin
      outstanding <= out_next;
      if (gnt_vld) begin
        rr_ptr <= (int'(gnt_idx) == NumPorts - 1) ? {IdxW{1'b0}} : gnt_idx + IdxW'(1);
      end
      if (!flush_i) begin
        flush_armed <= 1'b1;
      end else if (flush_start) begin
        flush_armed <= 1'b0;
      end
      case (state)
        IDLE:    if (flush_start) state <= DRAIN;
        DRAIN:   if (out_next == {OutW{1'b0}}) state <= WBUF;
        WBUF:    if (wbuffer_empty_i) state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_dcache_port_arb.sv
// Scoreboard bench for wt_dcache_port_arb (NumPorts=3, MaxOutst=4, StarveLimit=15).
module tb_wt_dcache_port_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rd_req = 3'b000;
  logic [2:0] rd_prio = 3'b000;
  logic [2:0] rd_ack;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic       mem_ready = 1'b1;
  logic       rsp_vld = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       wbuffer_empty = 1'b1;
  logic       flush_ack;
  logic       busy;
  logic       starve;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int gnt;
    bit stv;
    bit fack;
  } exp_t;
  exp_t sb[$];

  wt_dcache_port_arb #(.NumPorts(3), .MaxOutst(4), .StarveLimit(15)) dut (
    .clk_i(clk), .rst_i(rst), .rd_req_i(rd_req), .rd_prio_i(rd_prio),
    .rd_ack_o(rd_ack), .gnt_vld_o(gnt_vld), .gnt_idx_o(gnt_idx),
    .mem_ready_i(mem_ready), .rsp_vld_i(rsp_vld), .stall_i(stall),
    .flush_i(flush), .wbuffer_empty_i(wbuffer_empty), .flush_ack_o(flush_ack),
    .busy_o(busy), .starve_o(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input bit s, input bit f);
    exp_t e;
    e.gnt = g; e.stv = s; e.fack = f;
    sb.push_back(e);
  endtask

  // sample mid-cycle against the oldest expectation, then advance to posedge+1
  task automatic tick(input string tag);
    exp_t e;
    #3;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ack"}, 32'(rd_ack), (e.gnt < 0) ? 32'd0 : (32'd1 << e.gnt));
      chk({tag, "_vld"}, 32'(gnt_vld), (e.gnt < 0) ? 32'd0 : 32'd1);
      chk({tag, "_idx"}, 32'(gnt_idx), (e.gnt < 0) ? 32'd0 : 32'(e.gnt));
      chk({tag, "_starve"}, 32'(starve), 32'(e.stv));
      chk({tag, "_fack"}, 32'(flush_ack), 32'(e.fack));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(rd_ack), 32'd0);
    chk({tag, "_vld"}, 32'(gnt_vld), 32'd0);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'd0);
    chk({tag, "_fack"}, 32'(flush_ack), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_starve"}, 32'(starve), 32'd0);
  endtask

  initial begin
    int g;
    bit s;
    // reset with requests present: everything must stay quiet
    rd_req = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // two-class priority: ports 0/1 alternate, port 2 only wins once starved
    rd_req = 3'b111; rd_prio = 3'b011; rsp_vld = 1'b1;
    for (int k = 0; k < 17; k++) begin
      g = (k % 2 == 0) ? 0 : 1;
      s = 1'b0;
`ifdef WT_DCACHE_ARB_STARVE_EN
      if (k == 16) begin g = 2; s = 1'b1; end
`endif
      push(g, s, 1'b0);
    end
    for (int k = 0; k < 17; k++) tick("prio");
    rd_req = 3'b000;
    push(-1, 1'b0, 1'b0);
    tick("retire");
    rsp_vld = 1'b0;
    chk("busy_after_retire", 32'(busy), 32'd0);

    // outstanding limit: 4 grants, then blocked; one rsp allows exactly one more
    rd_req = 3'b001; rd_prio = 3'b000;
    for (int k = 0; k < 4; k++) push(0, 1'b0, 1'b0);
    push(-1, 1'b0, 1'b0);
    push(-1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) tick("maxout");
    chk("busy_full", 32'(busy), 32'd1);
    rsp_vld = 1'b1;
    push(0, 1'b0, 1'b0);
    tick("rsp_regrant");
    rsp_vld = 1'b0;
    push(-1, 1'b0, 1'b0);
    tick("full_again");

    // bring outstanding down to 2, then flush
    rd_req = 3'b000; rsp_vld = 1'b1;
    push(-1, 1'b0, 1'b0); push(-1, 1'b0, 1'b0);
    tick("pre_drain"); tick("pre_drain");
    rd_req = 3'b001; rsp_vld = 1'b0; flush = 1'b1; wbuffer_empty = 1'b0;
    push(-1, 1'b0, 1'b0); tick("flush_start");
    push(-1, 1'b0, 1'b0); tick("drain_wait");
    rsp_vld = 1'b1;
    push(-1, 1'b0, 1'b0); tick("drain_rsp1");
    push(-1, 1'b0, 1'b0); tick("drain_rsp2");
    rsp_vld = 1'b0;
    for (int k = 0; k < 5; k++) push(-1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick("wbuf_wait");
    chk("busy_wbuf", 32'(busy), 32'd1);
    wbuffer_empty = 1'b1;
    push(-1, 1'b0, 1'b0); tick("wbuf_empty");
    push(-1, 1'b0, 1'b1); tick("flush_ack");
    // flush_i still high: no new flush, grants resume
    push(0, 1'b0, 1'b0); tick("no_rearm");
    push(0, 1'b0, 1'b0); tick("no_rearm2");
    flush = 1'b0; rd_req = 3'b000; rsp_vld = 1'b1;
    push(-1, 1'b0, 1'b0); push(-1, 1'b0, 1'b0);
    tick("post_flush"); tick("post_flush");
    rsp_vld = 1'b0;
    chk("busy_post_flush", 32'(busy), 32'd0);

    // reset while in WBUF, then a held flush restarts from IDLE
    flush = 1'b1; wbuffer_empty = 1'b0;
    push(-1, 1'b0, 1'b0); tick("f2_start");
    push(-1, 1'b0, 1'b0); tick("f2_drain");
    rd_req = 3'b111; rst = 1'b1;
    #1;
    chk_all_zero("rst_in_wbuf");
    @(posedge clk);
    #1;
    rst = 1'b0; wbuffer_empty = 1'b1; rd_prio = 3'b111; rsp_vld = 1'b1;
    push(-1, 1'b0, 1'b0); push(-1, 1'b0, 1'b0); push(-1, 1'b0, 1'b0);
    push(-1, 1'b0, 1'b1); push(0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick("restart");

    // stall / mem_ready hold rr_ptr (now 1)
    flush = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) push(-1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick("stall");
    stall = 1'b0;
    push(1, 1'b0, 1'b0); tick("stall_release");
    mem_ready = 1'b0;
    push(-1, 1'b0, 1'b0); push(-1, 1'b0, 1'b0);
    tick("not_ready"); tick("not_ready");
    mem_ready = 1'b1;
    push(2, 1'b0, 1'b0); push(0, 1'b0, 1'b0);
    tick("ready_release"); tick("rr_wrap");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
